// File: rtl/rtc_bus_pkg.sv
// Shared constants for the RTC parallel-bus writer: register map, state encoding, field snapshot layout.
package rtc_bus_pkg;

  localparam logic [7:0] ADDR_MIN        = 8'h22;
  localparam logic [7:0] ADDR_HORA       = 8'h23;
  localparam logic [7:0] ADDR_DIA        = 8'h24;
  localparam logic [7:0] ADDR_MES        = 8'h25;
  localparam logic [7:0] ADDR_YEAR       = 8'h26;
  localparam logic [7:0] ADDR_MIN_TIMER  = 8'h42;
  localparam logic [7:0] ADDR_HORA_TIMER = 8'h43;
  localparam logic [7:0] ADDR_CMD        = 8'hF1;

  localparam int NUM_XFER = 8;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_A_SETUP  = 4'd1;
  localparam logic [3:0] ST_A_STROBE = 4'd2;
  localparam logic [3:0] ST_A_HOLD   = 4'd3;
  localparam logic [3:0] ST_A_GAP    = 4'd4;
  localparam logic [3:0] ST_D_SETUP  = 4'd5;
  localparam logic [3:0] ST_D_STROBE = 4'd6;
  localparam logic [3:0] ST_D_HOLD   = 4'd7;
  localparam logic [3:0] ST_D_GAP    = 4'd8;
  localparam logic [3:0] ST_FINISH   = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE     = ST_IDLE,
    S_A_SETUP  = ST_A_SETUP,
    S_A_STROBE = ST_A_STROBE,
    S_A_HOLD   = ST_A_HOLD,
    S_A_GAP    = ST_A_GAP,
    S_D_SETUP  = ST_D_SETUP,
    S_D_STROBE = ST_D_STROBE,
    S_D_HOLD   = ST_D_HOLD,
    S_D_GAP    = ST_D_GAP,
    S_FINISH   = ST_FINISH
  } state_t;

  typedef struct packed {
    logic [7:0] min_v;
    logic [7:0] hora;
    logic [7:0] dia;
    logic [7:0] mes;
    logic [7:0] year;
    logic [7:0] min_timer;
    logic [7:0] hora_timer;
  } fields_t;

  // Register address for each transfer slot, in bus write order.
  function automatic logic [7:0] xfer_addr(input logic [2:0] idx);
    logic [7:0] a;
    case (idx)
      3'd0:    a = ADDR_MIN;
      3'd1:    a = ADDR_HORA;
      3'd2:    a = ADDR_DIA;
      3'd3:    a = ADDR_MES;
      3'd4:    a = ADDR_YEAR;
      3'd5:    a = ADDR_MIN_TIMER;
      3'd6:    a = ADDR_HORA_TIMER;
      default: a = ADDR_CMD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/bin2bcd_sat8.sv
// Combinational 8-bit binary to packed two-digit BCD; inputs above 99 saturate to 8'h99.
module bin2bcd_sat8 (
  input  logic [7:0] i_bin,
  output logic [7:0] o_bcd
);

  logic [3:0] w_tens;
  logic [3:0] w_ones;

  assign w_tens = 4'(i_bin / 8'd10);
  assign w_ones = 4'(i_bin % 8'd10);
  assign o_bcd  = (i_bin > 8'd99) ? 8'h99 : {w_tens, w_ones};

endmodule

// File: rtl/rtc_bus_writer.sv
// Writes 7 snapshotted date/time fields (as BCD) plus a transfer command to the RTC over its muxed A/D bus.
// Sequence takes 16 phases of T_SU+T_PW+T_H+1 cycles; start is ignored while a sequence runs.
module rtc_bus_writer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SU     = 2,
  parameter int unsigned T_PW     = 4,
  parameter int unsigned T_H      = 2,
  parameter logic [7:0]  CMD_DATA = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_dia,
  input  logic [7:0] i_mes,
  input  logic [7:0] i_year,
  input  logic [7:0] i_hora,
  input  logic [7:0] i_min,
  input  logic [7:0] i_hora_timer,
  input  logic [7:0] i_min_timer,
  output logic [7:0] o_ad_out,
  output logic       o_ad_oe,
  output logic       o_ad_sel,
  output logic       o_cs_n,
  output logic       o_wr_n,
  output logic       o_rd_n,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [3:0] LD_SU = 4'(T_SU - 1);
  localparam logic [3:0] LD_PW = 4'(T_PW - 1);
  localparam logic [3:0] LD_H  = 4'(T_H - 1);

  state_t     r_state, w_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  fields_t    r_snap;
  logic [7:0] r_ad_out;
  logic       r_ad_sel;
  logic [7:0] w_bin, w_bcd, w_data;

  always_comb begin
    w_bin = 8'h00;
    case (r_idx)
      3'd0:    w_bin = r_snap.min_v;
      3'd1:    w_bin = r_snap.hora;
      3'd2:    w_bin = r_snap.dia;
      3'd3:    w_bin = r_snap.mes;
      3'd4:    w_bin = r_snap.year;
      3'd5:    w_bin = r_snap.min_timer;
      3'd6:    w_bin = r_snap.hora_timer;
      default: w_bin = 8'h00;
    endcase
  end

  bin2bcd_sat8 u_bcd (
    .i_bin(w_bin),
    .o_bcd(w_bcd)
  );

  assign w_data = (r_idx == 3'(NUM_XFER - 1)) ? CMD_DATA : w_bcd;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_idx_nxt = r_idx;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_nxt     = S_A_SETUP;
        w_cnt_nxt = LD_SU;
        w_idx_nxt = 3'd0;
      end
      S_A_SETUP, S_D_SETUP: if (r_cnt == 4'd0) begin
        w_nxt     = (r_state == S_A_SETUP) ? S_A_STROBE : S_D_STROBE;
        w_cnt_nxt = LD_PW;
      end else w_cnt_nxt = r_cnt - 4'd1;
      S_A_STROBE, S_D_STROBE: if (r_cnt == 4'd0) begin
        w_nxt     = (r_state == S_A_STROBE) ? S_A_HOLD : S_D_HOLD;
        w_cnt_nxt = LD_H;
      end else w_cnt_nxt = r_cnt - 4'd1;
      S_A_HOLD, S_D_HOLD: if (r_cnt == 4'd0) begin
        w_nxt = (r_state == S_A_HOLD) ? S_A_GAP : S_D_GAP;
      end else w_cnt_nxt = r_cnt - 4'd1;
      S_A_GAP: begin
        w_nxt     = S_D_SETUP;
        w_cnt_nxt = LD_SU;
      end
      S_D_GAP: if (r_idx == 3'(NUM_XFER - 1)) begin
        w_nxt = S_FINISH;
      end else begin
        w_nxt     = S_A_SETUP;
        w_cnt_nxt = LD_SU;
        w_idx_nxt = r_idx + 3'd1;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Bus value is only reloaded on entry to a SETUP state, so it never moves under an active strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= 3'd0;
      r_snap   <= '0;
      r_ad_out <= 8'h00;
      r_ad_sel <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == S_IDLE && i_start)
        r_snap <= '{min_v: i_min, hora: i_hora, dia: i_dia, mes: i_mes, year: i_year,
                    min_timer: i_min_timer, hora_timer: i_hora_timer};
      if (w_nxt == S_A_SETUP && r_state != S_A_SETUP) begin
        r_ad_out <= xfer_addr(w_idx_nxt);
        r_ad_sel <= 1'b0;
      end else if (r_state == S_A_GAP) begin
        r_ad_out <= w_data;
        r_ad_sel <= 1'b1;
      end
    end
  end

  always_comb begin
    o_cs_n  = 1'b1;
    o_wr_n  = 1'b1;
    o_ad_oe = 1'b0;
    o_busy  = 1'b1;
    o_done  = 1'b0;
    case (r_state)
      S_IDLE:   o_busy = 1'b0;
      S_FINISH: begin
        o_busy = 1'b0;
        o_done = 1'b1;
      end
      S_A_SETUP, S_A_HOLD, S_D_SETUP, S_D_HOLD: begin
        o_cs_n  = 1'b0;
        o_ad_oe = 1'b1;
      end
      S_A_STROBE, S_D_STROBE: begin
        o_cs_n  = 1'b0;
        o_ad_oe = 1'b1;
        o_wr_n  = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_ad_out = r_ad_out;
  assign o_ad_sel = r_ad_sel;
  assign o_rd_n   = 1'b1;

endmodule

// File: doc/rtc_bus_writer.md
Name: rtc_bus_writer

Overview:
- Downstream end of the date/time editing path: takes the binary field values (dia, mes, year, hora, min, hora_timer, min_timer) from the field editor and writes them to the external RTC chip.
- Uses the RTC's multiplexed address/data parallel bus, one address phase and one data phase per register.
- On a start pulse it snapshots all fields, converts each to packed BCD, performs 7 register writes, then writes the transfer command.
- Reports busy and signals completion with a one-cycle done pulse.

Parameters:
- T_SU, 2, clk cycles of cs_n low, wr_n high, before the strobe in each phase (range 1..15)
- T_PW, 4, clk cycles wr_n is low in each phase (range 1..15)
- T_H, 2, clk cycles wr_n high, cs_n still low, after the strobe (range 1..15)
- CMD_DATA, 8'h00, data byte written with the final transfer command

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to write all fields; ignored while busy
- dia, mes, year, hora, min, hora_timer, min_timer  in  8 each  binary field values
- ad_out  out  8  multiplexed address/data driven to the RTC
- ad_oe  out  1  1 = ad_out drives the bus (tri-state enable at top level)
- ad_sel  out  1  RTC A/D line: 0 = address phase, 1 = data phase; idles at 1
- cs_n  out  1  chip select, active low
- wr_n  out  1  write strobe, active low
- rd_n  out  1  read strobe; held at 1 by this block
- busy  out  1  a write sequence is in progress
- done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset is synchronous, active-high, and applies on the next clk edge, including mid-sequence.
- Reset state: state = IDLE, busy=0, done=0, cs_n=1, wr_n=1, rd_n=1, ad_sel=1, ad_oe=0, ad_out=8'h00, transfer index=0, snapshot registers cleared.
- IDLE: on start=1, register all 7 fields into snapshots; busy=1 from the next cycle. Later input changes have no effect until the next start. start while busy is ignored, with no queuing.
- BCD conversion: value 0..99 -> {tens, ones} nibbles, e.g. 31 -> 8'h31. Values >99 saturate to 8'h99. No range checking per field.
- Transfer order, index 0..7 (address, data):
  - 0: min (8'h22, BCD)
  - 1: hora (8'h23, BCD)
  - 2: dia (8'h24, BCD)
  - 3: mes (8'h25, BCD)
  - 4: year (8'h26, BCD)
  - 5: min_timer (8'h42, BCD)
  - 6: hora_timer (8'h43, BCD)
  - 7: command (8'hF1, CMD_DATA)
- Each transfer has two phases: address (ad_sel=0, ad_out=address), then data (ad_sel=1, ad_out=data).
- Phase states, in order:
  - SETUP, T_SU cycles: cs_n=0, wr_n=1, ad_oe=1.
  - STROBE, T_PW cycles: wr_n=0.
  - HOLD, T_H cycles: wr_n=1, cs_n=0; ad_out and ad_sel stable.
  - GAP, 1 cycle: cs_n=1, wr_n=1, ad_oe=0.
- ad_out and ad_sel change only in the first SETUP cycle of a phase, never while wr_n=0.
- State machine: IDLE -> A_SETUP -> A_STROBE -> A_HOLD -> A_GAP -> D_SETUP -> D_STROBE -> D_HOLD -> D_GAP -> (index<7 ? A_SETUP with index+1 : FINISH) -> IDLE.
- A single down-counter, width 4, is loaded with the phase length on entry to each timed state.
- Phase length = T_SU+T_PW+T_H+1 cycles. With defaults: 9 cycles per phase, 18 per transfer, 144 cycles total.
- busy is high for exactly 16*(T_SU+T_PW+T_H+1) cycles.
- FINISH: busy=0, done=1 for one cycle, return to IDLE. A start in the FINISH cycle is ignored.
- rd_n is constant 1. The block never reads.

Decomposition:
- Package rtc_bus_pkg:
  - RTC register address constants (ADDR_MIN..ADDR_HORA_TIMER, ADDR_CMD)
  - state encoding localparams (4-bit)
  - NUM_XFER=8
- Sub-module bin2bcd_sat8: combinational 8-bit binary -> packed BCD with saturation at 99. Instantiated once on the index-muxed snapshot value.

Test Plan:
- Reset, then idle 10 cycles -> cs_n=1, wr_n=1, rd_n=1, ad_sel=1, ad_oe=0, busy=0, done=0 throughout.
- Defaults; dia=31, mes=12, year=17, hora=9, min=45, hora_timer=1, min_timer=30; pulse start -> 16 wr_n low pulses of 4 cycles each. Bus captures at wr_n rising edge: (22,45)(23,09)(24,31)(25,12)(26,17)(42,30)(43,01)(F1,00). busy high 144 cycles, then done for 1 cycle.
- year=150, min=99, hora=100 -> data bytes 8'h99, 8'h99, 8'h99.
- start re-pulsed at cycles 5 and 80 of a sequence; fields changed mid-sequence -> no extra transfers, data equals the values snapshotted at the original start.
- reset asserted during the data STROBE of transfer 3 -> next cycle wr_n=1, cs_n=1, ad_oe=0, busy=0, no done pulse. A new start then runs a full 144-cycle sequence from index 0.
- T_SU=1, T_PW=1, T_H=1 -> 4-cycle phases, busy exactly 64 cycles. Checker confirms ad_out/ad_sel never change while wr_n=0.
